// File: rtl/dm_lane_seq.sv
// dm_lane_seq: multi-lane DDR3 DM write-side sequencer (clk_div domain).
//
// Turns a per-burst byte mask into per-lane din/tin nibbles for the DM
// serializers. It also drives dci_disable around each write burst and runs a
// per-lane output-delay load sequence. One clk cycle carries 4 DDR beats, so
// a BL8 burst takes 2 cycles.
//
// Optional feature: define DM_LANE_SEQ_BACK2BACK_EN for seamless back-to-back
// bursts. A new burst accepted in DATA1 goes straight to DATA0 with no
// POST or PRE.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   wr_start, wr_mask        burst start and per-lane beat mask (1 = mask byte)
//   wr_ready, busy           start can be accepted / write FSM not idle
//   dm_din, dm_tin           per-lane data / tristate nibbles (bit 0 = first beat)
//   dci_disable              DCI termination disable
//   dly_addr/data/we         delay staging register write
//   dly_apply                start the delay load sequence
//   dly_out, set_odelay,     delay bus, one-hot per-lane set pulse,
//   ld_odelay, dly_busy      broadcast load pulse, sequence active

package dm_lane_seq_pkg;
  typedef enum logic [1:0] {M_HIZ, M_LOW, M_LO, M_HI} lane_mode_t;

  // Per-lane control for the next output cycle.
  typedef struct packed {
    lane_mode_t mode;
    logic [7:0] mask;
  } lane_ctl_t;
endpackage

// One lane: registered DM nibbles plus this lane's delay staging register.
module dm_lane_seq_lane
  import dm_lane_seq_pkg::*;
#(
  parameter int DLY_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  lane_ctl_t            ctl,
  input  logic                 stg_we,
  input  logic [DLY_WIDTH-1:0] stg_data,
  output logic [3:0]           din,
  output logic [3:0]           tin,
  output logic [DLY_WIDTH-1:0] stg
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din <= '0;
      tin <= '1;
    end else begin
      case (ctl.mode)
        M_LOW:   begin din <= '0;             tin <= '0; end
        M_LO:    begin din <= ctl.mask[3:0];  tin <= '0; end
        M_HI:    begin din <= ctl.mask[7:4];  tin <= '0; end
        default: begin din <= '0;             tin <= '1; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         stg <= '0;
    else if (stg_we) stg <= stg_data;
  end
endmodule

module dm_lane_seq
  import dm_lane_seq_pkg::*;
#(
  parameter  int NUM_LANES = 2,
  parameter  int PREAMBLE  = 1,
  parameter  int POSTAMBLE = 1,
  parameter  int DLY_WIDTH = 8,
  localparam int AW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_start,
  input  logic [NUM_LANES*8-1:0] wr_mask,
  output logic                   wr_ready,
  output logic                   busy,
  output logic [NUM_LANES*4-1:0] dm_din,
  output logic [NUM_LANES*4-1:0] dm_tin,
  output logic                   dci_disable,
  input  logic [AW-1:0]          dly_addr,
  input  logic [DLY_WIDTH-1:0]   dly_data,
  input  logic                   dly_we,
  input  logic                   dly_apply,
  output logic [DLY_WIDTH-1:0]   dly_out,
  output logic [NUM_LANES-1:0]   set_odelay,
  output logic                   ld_odelay,
  output logic                   dly_busy
);
`ifdef DM_LANE_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PRE, DATA0, DATA1, POST} wr_state_t;
  typedef enum logic [1:0] {D_IDLE, D_SET, D_LD} dly_state_t;

  // Counters hold remaining cycles minus one, so PRE/POST exit on zero.
  localparam logic [1:0]    PRE_LD   = 2'(PREAMBLE - 1);
  localparam logic [1:0]    POST_LD  = 2'(POSTAMBLE - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LANES - 1);
  localparam logic [AW:0]   NLANES_W = (AW+1)'(NUM_LANES);

  // ---------------- write FSM ----------------
  wr_state_t              w_state, w_nxt;
  logic [1:0]             cnt, cnt_nxt;
  logic [NUM_LANES*8-1:0] mask_q, mask_nxt;
  lane_mode_t             mode_nxt;

  always_comb begin
    w_nxt    = w_state;
    cnt_nxt  = cnt;
    mask_nxt = mask_q;
    case (w_state)
      IDLE: if (wr_start) begin
        mask_nxt = wr_mask;
        w_nxt    = PRE;
        cnt_nxt  = PRE_LD;
      end
      PRE: begin
        if (cnt == 2'd0) w_nxt   = DATA0;
        else             cnt_nxt = cnt - 2'd1;
      end
      DATA0: w_nxt = DATA1;
      DATA1: begin
        if (B2B && wr_start) begin
          // Seamless chaining: termination and drive stay on across the seam.
          mask_nxt = wr_mask;
          w_nxt    = DATA0;
        end else begin
          w_nxt   = POST;
          cnt_nxt = POST_LD;
        end
      end
      POST: begin
        if (cnt == 2'd0) w_nxt   = IDLE;
        else             cnt_nxt = cnt - 2'd1;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    mode_nxt = M_HIZ;
    case (w_nxt)
      PRE, POST: mode_nxt = M_LOW;
      DATA0:     mode_nxt = M_LO;
      DATA1:     mode_nxt = M_HI;
      default:   mode_nxt = M_HIZ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= IDLE;
      cnt         <= '0;
      mask_q      <= '0;
      busy        <= 1'b0;
      wr_ready    <= 1'b1;
      dci_disable <= 1'b0;
    end else begin
      w_state     <= w_nxt;
      cnt         <= cnt_nxt;
      mask_q      <= mask_nxt;
      busy        <= (w_nxt != IDLE);
      wr_ready    <= (w_nxt == IDLE) || (B2B && (w_nxt == DATA1));
      dci_disable <= (w_nxt != IDLE);
    end
  end

  // ---------------- delay sequencer ----------------
  dly_state_t                            d_state, d_nxt;
  logic [AW-1:0]                         idx, idx_nxt;
  logic [NUM_LANES-1:0][DLY_WIDTH-1:0]   stg;
  logic [DLY_WIDTH-1:0]                  stg_sel;
  logic [NUM_LANES-1:0]                  set_nxt;
  logic [NUM_LANES-1:0]                  lane_we;
  logic                                  stg_wr_ok;

  // Staging writes only while idle and only to lanes that exist.
  assign stg_wr_ok = dly_we && (d_state == D_IDLE) && ({1'b0, dly_addr} < NLANES_W);

  always_comb begin
    d_nxt   = d_state;
    idx_nxt = idx;
    case (d_state)
      D_IDLE: if (dly_apply) begin
        d_nxt   = D_SET;
        idx_nxt = '0;
      end
      D_SET: begin
        if (idx == LAST_IDX) d_nxt   = D_LD;
        else                 idx_nxt = idx + AW'(1);
      end
      D_LD:    d_nxt = D_IDLE;
      default: d_nxt = D_IDLE;
    endcase
  end

  always_comb begin
    stg_sel = '0;
    set_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx_nxt == AW'(i)) begin
        stg_sel    = stg[i];
        set_nxt[i] = (d_nxt == D_SET);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state    <= D_IDLE;
      idx        <= '0;
      dly_out    <= '0;
      set_odelay <= '0;
      ld_odelay  <= 1'b0;
      dly_busy   <= 1'b0;
    end else begin
      d_state    <= d_nxt;
      idx        <= idx_nxt;
      set_odelay <= set_nxt;
      ld_odelay  <= (d_nxt == D_LD);
      dly_busy   <= (d_nxt != D_IDLE);
      if (d_nxt == D_SET) dly_out <= stg_sel;  // holds last value otherwise
    end
  end

  // ---------------- lane array ----------------
  lane_ctl_t ctl [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign ctl[g]     = '{mode: mode_nxt, mask: mask_nxt[8*g +: 8]};
    assign lane_we[g] = stg_wr_ok && (dly_addr == AW'(g));

    dm_lane_seq_lane #(.DLY_WIDTH(DLY_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ctl      (ctl[g]),
      .stg_we   (lane_we[g]),
      .stg_data (dly_data),
      .din      (dm_din[4*g +: 4]),
      .tin      (dm_tin[4*g +: 4]),
      .stg      (stg[g])
    );
  end
endmodule

// File: tb/tb_dm_lane_seq.sv
// Directed bench for dm_lane_seq: instance a (2 lanes, PRE=1, POST=1) and
// instance b (3 lanes, PRE=3, POST=2).
module tb_dm_lane_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a
  logic        a_wr_start = 0, a_wr_ready, a_busy, a_dci;
  logic [15:0] a_wr_mask = '0;
  logic [7:0]  a_din, a_tin;
  logic [0:0]  a_dly_addr = '0;
  logic [7:0]  a_dly_data = '0, a_dly_out;
  logic        a_dly_we = 0, a_dly_apply = 0, a_ld, a_dly_busy;
  logic [1:0]  a_set;

  // instance b
  logic        b_wr_start = 0, b_wr_ready, b_busy, b_dci;
  logic [23:0] b_wr_mask = '0;
  logic [11:0] b_din, b_tin;
  logic [1:0]  b_dly_addr = '0;
  logic [7:0]  b_dly_data = '0, b_dly_out;
  logic        b_dly_we = 0, b_dly_apply = 0, b_ld, b_dly_busy;
  logic [2:0]  b_set;

  dm_lane_seq #(.NUM_LANES(2), .PREAMBLE(1), .POSTAMBLE(1), .DLY_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .wr_start(a_wr_start), .wr_mask(a_wr_mask),
    .wr_ready(a_wr_ready), .busy(a_busy), .dm_din(a_din), .dm_tin(a_tin),
    .dci_disable(a_dci), .dly_addr(a_dly_addr), .dly_data(a_dly_data),
    .dly_we(a_dly_we), .dly_apply(a_dly_apply), .dly_out(a_dly_out),
    .set_odelay(a_set), .ld_odelay(a_ld), .dly_busy(a_dly_busy));

  dm_lane_seq #(.NUM_LANES(3), .PREAMBLE(3), .POSTAMBLE(2), .DLY_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .wr_start(b_wr_start), .wr_mask(b_wr_mask),
    .wr_ready(b_wr_ready), .busy(b_busy), .dm_din(b_din), .dm_tin(b_tin),
    .dci_disable(b_dci), .dly_addr(b_dly_addr), .dly_data(b_dly_data),
    .dly_we(b_dly_we), .dly_apply(b_dly_apply), .dly_out(b_dly_out),
    .set_odelay(b_set), .ld_odelay(b_ld), .dly_busy(b_dly_busy));

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stage_a(input logic [0:0] addr, input logic [7:0] data);
    a_dly_addr = addr; a_dly_data = data; a_dly_we = 1; tick(); a_dly_we = 0;
  endtask

  task automatic stage_b(input logic [1:0] addr, input logic [7:0] data);
    b_dly_addr = addr; b_dly_data = data; b_dly_we = 1; tick(); b_dly_we = 0;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (a_tin !== 8'hFF) begin errors++; $display("FAIL rst_tin: got %h exp ff", a_tin); end
    checks++; if (a_din !== 8'h00) begin errors++; $display("FAIL rst_din: got %h exp 00", a_din); end
    checks++; if ({a_dci, a_busy, a_wr_ready} !== 3'b001) begin errors++; $display("FAIL rst_ctl: got %b exp 001", {a_dci, a_busy, a_wr_ready}); end
    checks++; if ({a_set, a_ld, a_dly_busy} !== 4'b0000) begin errors++; $display("FAIL rst_dly: got %b exp 0000", {a_set, a_ld, a_dly_busy}); end
    checks++; if (a_dly_out !== 8'h00) begin errors++; $display("FAIL rst_dly_out: got %h exp 00", a_dly_out); end
    rst = 0;
    tick();
  endtask

  task automatic test_single_burst();
    a_wr_mask = 16'hA53C; a_wr_start = 1; tick(); a_wr_start = 0;
    // PRE
    checks++; if ({a_tin, a_din} !== 16'h0000) begin errors++; $display("FAIL s1_pre_tin_din: got %h exp 0000", {a_tin, a_din}); end
    checks++; if ({a_dci, a_busy, a_wr_ready} !== 3'b110) begin errors++; $display("FAIL s1_pre_ctl: got %b exp 110", {a_dci, a_busy, a_wr_ready}); end
    tick();
    // DATA0; a start here must be ignored
    checks++; if (a_din !== 8'h5C) begin errors++; $display("FAIL s1_data0_din: got %h exp 5c", a_din); end
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL s1_data0_ready: got %b exp 0", a_wr_ready); end
    a_wr_mask = 16'h0FF0; a_wr_start = 1; tick(); a_wr_start = 0;
    checks++; if ({a_din, a_tin} !== 16'hA300) begin errors++; $display("FAIL s1_data1_din_tin: got %h exp a300", {a_din, a_tin}); end
    tick();
    checks++; if ({a_din, a_tin, 7'd0, a_dci} !== 24'h000001) begin errors++; $display("FAIL s1_post: got %h exp 000001", {a_din, a_tin, 7'd0, a_dci}); end
    tick();
    checks++; if (a_tin !== 8'hFF) begin errors++; $display("FAIL s1_idle_tin: got %h exp ff", a_tin); end
    checks++; if ({a_dci, a_busy, a_wr_ready} !== 3'b001) begin errors++; $display("FAIL s1_idle_ctl: got %b exp 001", {a_dci, a_busy, a_wr_ready}); end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL s1_ignored_start: busy got %b exp 0", a_busy); end
  endtask

  task automatic test_back_to_back();
    a_wr_mask = 16'hA53C; a_wr_start = 1; tick(); a_wr_start = 0;
    tick(); tick();  // now in DATA1
`ifdef DM_LANE_SEQ_BACK2BACK_EN
    checks++; if (a_wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", a_wr_ready); end
    a_wr_mask = 16'h0FF0; a_wr_start = 1; tick(); a_wr_start = 0;
    checks++; if ({a_din, a_tin} !== 16'hF000) begin errors++; $display("FAIL b2b_data0: got %h exp f000", {a_din, a_tin}); end
    checks++; if (a_dci !== 1'b1) begin errors++; $display("FAIL b2b_dci: got %b exp 1", a_dci); end
    tick();
    checks++; if ({a_din, a_tin} !== 16'h0F00) begin errors++; $display("FAIL b2b_data1: got %h exp 0f00", {a_din, a_tin}); end
    tick();
    checks++; if ({a_din, a_tin, 7'd0, a_dci} !== 24'h000001) begin errors++; $display("FAIL b2b_post: got %h exp 000001", {a_din, a_tin, 7'd0, a_dci}); end
    tick();
    checks++; if ({a_tin, 7'd0, a_busy} !== 16'hFF00) begin errors++; $display("FAIL b2b_idle: got %h exp ff00", {a_tin, 7'd0, a_busy}); end
`else
    checks++; if (a_wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b exp 0", a_wr_ready); end
    a_wr_mask = 16'h0FF0; a_wr_start = 1; tick(); a_wr_start = 0;
    checks++; if ({a_din, a_tin, 7'd0, a_dci} !== 24'h000001) begin errors++; $display("FAIL b2b_post: got %h exp 000001", {a_din, a_tin, 7'd0, a_dci}); end
    tick();
    checks++; if ({a_tin, 7'd0, a_busy} !== 16'hFF00) begin errors++; $display("FAIL b2b_idle: got %h exp ff00", {a_tin, 7'd0, a_busy}); end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored: busy got %b exp 0", a_busy); end
`endif
    tick();
  endtask

  task automatic test_delay_seq();
    stage_a(1'b0, 8'h1B);
    stage_a(1'b1, 8'h42);
    a_dly_apply = 1; tick(); a_dly_apply = 0;
    checks++; if ({a_set, a_dly_out} !== 10'b01_00011011) begin errors++; $display("FAIL d_lane0: got %b_%h exp 01_1b", a_set, a_dly_out); end
    checks++; if ({a_dly_busy, a_ld} !== 2'b10) begin errors++; $display("FAIL d_lane0_busy: got %b exp 10", {a_dly_busy, a_ld}); end
    // write and apply while busy must both be ignored
    a_dly_addr = 1'b0; a_dly_data = 8'hFF; a_dly_we = 1; a_dly_apply = 1; tick(); a_dly_we = 0; a_dly_apply = 0;
    checks++; if ({a_set, a_dly_out} !== 10'b10_01000010) begin errors++; $display("FAIL d_lane1: got %b_%h exp 10_42", a_set, a_dly_out); end
    tick();
    checks++; if ({a_set, a_ld, a_dly_busy} !== 4'b0011) begin errors++; $display("FAIL d_ld: got %b exp 0011", {a_set, a_ld, a_dly_busy}); end
    tick();
    checks++; if ({a_ld, a_dly_busy} !== 2'b00) begin errors++; $display("FAIL d_done: got %b exp 00", {a_ld, a_dly_busy}); end
    checks++; if (a_dly_out !== 8'h42) begin errors++; $display("FAIL d_hold: got %h exp 42", a_dly_out); end
    tick();
    checks++; if ({a_set, a_dly_busy} !== 3'b000) begin errors++; $display("FAIL d_no_second: got %b exp 000", {a_set, a_dly_busy}); end
    a_dly_apply = 1; tick(); a_dly_apply = 0;
    checks++; if (a_dly_out !== 8'h1B) begin errors++; $display("FAIL d_stage_kept: got %h exp 1b", a_dly_out); end
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    int ld_seen;
    a_wr_mask = 16'hA53C; a_wr_start = 1; tick(); a_wr_start = 0;
    tick();  // DATA0
    #2 rst = 1;
    #1;
    checks++; if ({a_tin, a_din} !== 16'hFF00) begin errors++; $display("FAIL rm_tin_din: got %h exp ff00", {a_tin, a_din}); end
    checks++; if ({a_dci, a_busy, a_wr_ready} !== 3'b001) begin errors++; $display("FAIL rm_ctl: got %b exp 001", {a_dci, a_busy, a_wr_ready}); end
    #2 rst = 0;
    tick();
    checks++; if ({a_tin, 7'd0, a_busy} !== 16'hFF00) begin errors++; $display("FAIL rm_stays_idle: got %h exp ff00", {a_tin, 7'd0, a_busy}); end
    stage_a(1'b0, 8'h5A);
    a_dly_apply = 1; tick(); a_dly_apply = 0;  // D_SET lane0
    #2 rst = 1;
    #1;
    checks++; if ({a_set, a_dly_busy, a_dly_out} !== 11'd0) begin errors++; $display("FAIL rm_dly: got %b %b %h exp 00 0 00", a_set, a_dly_busy, a_dly_out); end
    #2 rst = 0;
    ld_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_ld !== 1'b0) ld_seen++;
    end
    checks++; if (ld_seen !== 0) begin errors++; $display("FAIL rm_no_ld: got %0d pulses exp 0", ld_seen); end
    a_dly_apply = 1; tick(); a_dly_apply = 0;
    checks++; if (a_dly_out !== 8'h00) begin errors++; $display("FAIL rm_stage_cleared: got %h exp 00", a_dly_out); end
    tick(); tick(); tick();
  endtask

  task automatic test_simultaneous();
    logic [11:0] din_t [9];
    logic [11:0] tin_t [9];
    logic        dci_t [9];
    logic [2:0]  set_t [9];
    logic        ld_t  [9];
    logic        db_t  [9];
    logic [7:0]  out_t [9];
    int dci_cnt;
    din_t = '{12'h000, 12'h000, 12'h000, 12'h3A0, 12'hC5F, 12'h000, 12'h000, 12'h000, 12'h000};
    tin_t = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'hFFF};
    dci_t = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    set_t = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    ld_t  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    db_t  = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    out_t = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
    stage_b(2'd0, 8'h11);
    stage_b(2'd1, 8'h22);
    stage_b(2'd2, 8'h33);
    stage_b(2'd3, 8'h77);  // no such lane
    b_wr_mask = 24'hC35AF0; b_wr_start = 1; b_dly_apply = 1;
    tick();
    b_wr_start = 0; b_dly_apply = 0;
    dci_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (b_dci === 1'b1) dci_cnt++;
      checks++; if (b_din !== din_t[k]) begin errors++; $display("FAIL sim_din[%0d]: got %h exp %h", k, b_din, din_t[k]); end
      checks++; if (b_tin !== tin_t[k]) begin errors++; $display("FAIL sim_tin[%0d]: got %h exp %h", k, b_tin, tin_t[k]); end
      checks++; if (b_dci !== dci_t[k]) begin errors++; $display("FAIL sim_dci[%0d]: got %b exp %b", k, b_dci, dci_t[k]); end
      checks++; if (b_set !== set_t[k]) begin errors++; $display("FAIL sim_set[%0d]: got %b exp %b", k, b_set, set_t[k]); end
      checks++; if (b_ld !== ld_t[k]) begin errors++; $display("FAIL sim_ld[%0d]: got %b exp %b", k, b_ld, ld_t[k]); end
      checks++; if (b_dly_busy !== db_t[k]) begin errors++; $display("FAIL sim_dly_busy[%0d]: got %b exp %b", k, b_dly_busy, db_t[k]); end
      checks++; if (b_dly_out !== out_t[k]) begin errors++; $display("FAIL sim_dly_out[%0d]: got %h exp %h", k, b_dly_out, out_t[k]); end
      tick();
    end
    checks++; if (dci_cnt !== 7) begin errors++; $display("FAIL sim_dci_len: got %0d exp 7", dci_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_delay_seq();
    test_reset_mid();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_lane_seq.md
Name: dm_lane_seq

Overview:
- Multi-lane DDR3 DM write-side sequencer, one instance per memory channel.
- Converts a per-burst byte-mask command into per-lane 4-bit `din`/`tin` nibbles for the DM serializers, plus DCI-disable timing around each write.
- Also sequences per-lane output-delay loads: stage values, then issue per-lane set pulses and a broadcast load pulse.
- Runs in the clk_div domain; one clk cycle = 4 DDR beats, so BL8 = 2 cycles.

Parameters:
- NUM_LANES, 2, number of byte lanes (1..8).
- PREAMBLE, 1, driven-low cycles before data (1..3).
- POSTAMBLE, 1, driven-low cycles after data (1..3).
- DLY_WIDTH, 8, delay value width (3 LSB fine).

Ports:
- clk  in  1  clk_div-rate system clock.
- rst  in  1  async active-high reset.
- wr_start  in  1  start BL8 DM burst; accepted only when wr_ready=1.
- wr_mask  in  NUM_LANES*8  per lane i, bits [8i+7:8i] = beats 7..0; 1 = mask byte.
- wr_ready  out  1  burst start may be accepted this cycle.
- busy  out  1  write FSM not IDLE.
- dm_din  out  NUM_LANES*4  per-lane serializer data nibble; bit 0 = first beat.
- dm_tin  out  NUM_LANES*4  per-lane tristate nibble; 1 = high-Z.
- dci_disable  out  1  DCI termination disable.
- dly_addr  in  log2(NUM_LANES) (min 1)  staging register select.
- dly_data  in  DLY_WIDTH  value to stage.
- dly_we  in  1  write staging register.
- dly_apply  in  1  start delay load sequence.
- dly_out  out  DLY_WIDTH  delay bus to lane delay blocks.
- set_odelay  out  NUM_LANES  one-hot per-lane set pulse.
- ld_odelay  out  1  broadcast load pulse.
- dly_busy  out  1  delay sequence active.

Behaviour:
- Reset values (async):
  - State IDLE.
  - dm_din = 0, dm_tin = all 1.
  - dci_disable = 0, busy = 0, wr_ready = 1.
  - Staging registers = 0, dly_out = 0, set_odelay = 0, ld_odelay = 0, dly_busy = 0.
- All outputs are registered.
- Write FSM states: IDLE, PRE, DATA0, DATA1, POST.
  - wr_start accepted in IDLE: wr_mask captured, PRE entered next edge.
  - PRE lasts PREAMBLE cycles (down-counter): dm_tin = 0, dm_din = 0, dci_disable = 1.
  - DATA0: each lane din = mask[3:0], tin = 0.
  - DATA1: each lane din = mask[7:4], tin = 0.
  - POST lasts POSTAMBLE cycles: din = 0, tin = 0, dci_disable = 1.
  - After POST, return to IDLE: tin = all 1, dci_disable = 0 in the IDLE cycle.
- Latency:
  - wr_start at cycle N → first PRE output at N+1.
  - DATA0 output at N+1+PREAMBLE.
  - Last dci_disable=1 cycle at N+2+PREAMBLE+POSTAMBLE.
- wr_ready = (state==IDLE), or per the optional feature. wr_start with wr_ready=0 is ignored; no error flag.
- Delay sequencer states: D_IDLE, D_SET, D_LD.
  - dly_we in D_IDLE: staging[dly_addr] <= dly_data. dly_we ignored while dly_busy. Out-of-range dly_addr (≥NUM_LANES) ignored.
  - dly_apply in D_IDLE: enter D_SET with lane index 0. dly_apply while busy is ignored.
  - D_SET, one cycle per lane i = 0..NUM_LANES-1: dly_out = staging[i], set_odelay = 1<<i.
  - D_LD: single cycle, ld_odelay = 1, set_odelay = 0. Then back to D_IDLE.
  - dly_busy = 1 from the cycle after dly_apply through the D_LD cycle.
  - dly_out holds its last value in D_IDLE.
- The two FSMs are independent; simultaneous wr_start and dly_apply are both accepted.
- Reset mid-burst or mid-sequence: immediate return to reset values. No partial ld_odelay is issued.

Optional Feature:
- Macro: DM_LANE_SEQ_BACK2BACK_EN.
- Defined:
  - wr_ready is also 1 in DATA1.
  - wr_start accepted in DATA1 captures the new mask and goes DATA1 → DATA0 directly, with no POST/PRE. tin stays 0 and dci_disable stays 1 across the seam.
  - Chains of any length are allowed.
- Undefined:
  - wr_ready = 1 only in IDLE.
  - A new burst always incurs PREAMBLE + POSTAMBLE.

Test Plan:
1. NUM_LANES=2, PREAMBLE=1, POSTAMBLE=1, wr_start at cycle 10, wr_mask=16'hA53C → expected outputs:
   - Cycle 11: tin=8'h00, din=8'h00, dci_disable=1.
   - Cycle 12: din=8'h5C.
   - Cycle 13: din=8'hA3.
   - Cycle 14: din=0, tin=0.
   - Cycle 15: tin=8'hFF, dci_disable=0, busy=0.
2. wr_start in cycle 12 of scenario 1 → ignored, without the macro (wr_ready=0). With the macro, a second wr_start in the DATA1 cycle with mask 16'h0FF0 → next cycle din=8'hF0, then 8'h0F, with no PRE gap.
3. dly_we lane0=8'h1B, lane1=8'h42; dly_apply at cycle 20 → expected outputs:
   - Cycle 21: set_odelay=2'b01, dly_out=8'h1B.
   - Cycle 22: set_odelay=2'b10, dly_out=8'h42.
   - Cycle 23: ld_odelay=1.
   - dly_busy=1 for cycles 21-23.
4. dly_we and dly_apply during dly_busy → staging unchanged, no second sequence. dly_addr=2 with NUM_LANES=2 → ignored.
5. rst asserted during DATA0 → same cycle (async) tin=all 1, din=0, dci_disable=0, busy=0. rst asserted during D_SET lane0 → no ld_odelay ever pulses.
6. PREAMBLE=3, POSTAMBLE=2 → dci_disable=1 for exactly 7 cycles per burst. wr_start and dly_apply in the same cycle → both sequences complete with correct timing.
